// File: rtl/rc5_mon_pkg.sv
// rtl/rc5_mon_pkg.sv - shared state encoding and alarm_code bit positions for the RC5 output monitor
package rc5_mon_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MONITOR = 2'd1,
      ALARM   = 2'd2
   } mon_state_t;

   localparam int ALM_STUCK = 0;
   localparam int ALM_SAT   = 1;

endpackage

// File: rtl/rc5_repeat_detector.sv
// rtl/rc5_repeat_detector.sv - tracks runs of identical accepted blocks and flags a stuck run
module rc5_repeat_detector #(
   parameter int DATA_W      = 64,
   parameter int STUCK_LIMIT = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clr,
   input  logic              i_accept,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_stuck_evt
);

   localparam int RUN_W = $clog2(STUCK_LIMIT + 1);
   localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(STUCK_LIMIT);

   logic [DATA_W-1:0] r_prev;
   logic [RUN_W-1:0]  r_run;
   logic              r_have_prev;
   logic [RUN_W-1:0]  w_run_next;

   // r_have_prev keeps the first block after reset/clr from matching the zeroed history
   always_comb begin
      w_run_next = RUN_W'(1);
      if (r_have_prev && (i_data == r_prev)) begin
         if (r_run != RUN_LIMIT) begin
            w_run_next = r_run + 1'b1;
         end else begin
            w_run_next = r_run;
         end
      end
   end

   assign o_stuck_evt = i_accept && (w_run_next == RUN_LIMIT);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prev      <= '0;
         r_run       <= '0;
         r_have_prev <= 1'b0;
      end else if (i_clr) begin
         r_prev      <= '0;
         r_run       <= '0;
         r_have_prev <= 1'b0;
      end else if (i_accept) begin
         r_prev      <= i_data;
         r_run       <= w_run_next;
         r_have_prev <= 1'b1;
      end
   end

endmodule

// File: rtl/rc5_out_monitor.sv
// rtl/rc5_out_monitor.sv - RC5 output monitor: one-stage forwarding buffer, block counter,
// stuck/saturation alarm that quarantines the datapath until clr or reset
module rc5_out_monitor
   import rc5_mon_pkg::*;
#(
   parameter int DATA_W       = 64,
   parameter int CNT_W        = 32,
   parameter int STUCK_LIMIT  = 4,
   parameter bit SAT_ALARM_EN = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clr,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_in_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic [CNT_W-1:0]  o_blk_cnt,
   output logic              o_cnt_sat,
   output logic              o_alarm,
   output logic [1:0]        o_alarm_code
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   mon_state_t        r_state;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic [CNT_W-1:0]  r_blk_cnt;
   logic              r_alarm;
   logic [1:0]        r_alarm_code;

   logic w_in_ready;
   logic w_accept;
   logic w_cnt_max;
   logic w_stuck_evt;
   logic w_sat_evt;
   logic w_alarm_evt;

   assign w_cnt_max   = (r_blk_cnt == CNT_MAX);
   assign w_in_ready  = i_rst_n && (r_state != ALARM) && !i_clr && (!r_out_valid || i_out_ready);
   assign w_accept    = i_in_valid && w_in_ready;
   assign w_sat_evt   = SAT_ALARM_EN && w_accept && (r_blk_cnt == (CNT_MAX - 1'b1));
   assign w_alarm_evt = w_stuck_evt || w_sat_evt;

   rc5_repeat_detector #(
      .DATA_W      (DATA_W),
      .STUCK_LIMIT (STUCK_LIMIT)
   ) u_repeat (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_clr       (i_clr),
      .i_accept    (w_accept),
      .i_data      (i_in_data),
      .o_stuck_evt (w_stuck_evt)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_blk_cnt    <= '0;
         r_alarm      <= 1'b0;
         r_alarm_code <= 2'b00;
      end else if (i_clr) begin
         // the output buffer is not part of the cleared state; a pending handshake still completes
         r_state      <= IDLE;
         r_blk_cnt    <= '0;
         r_alarm      <= 1'b0;
         r_alarm_code <= 2'b00;
         if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
         end
      end else begin
         if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_accept) begin
            if (!w_cnt_max) begin
               r_blk_cnt <= r_blk_cnt + 1'b1;
            end
            // the offending block is counted but never forwarded
            if (w_alarm_evt) begin
               r_state                 <= ALARM;
               r_alarm                 <= 1'b1;
               r_alarm_code[ALM_STUCK] <= w_stuck_evt;
               r_alarm_code[ALM_SAT]   <= w_sat_evt;
               r_out_valid             <= 1'b0;
               r_out_data              <= '0;
            end else begin
               r_state     <= MONITOR;
               r_out_valid <= 1'b1;
               r_out_data  <= i_in_data;
            end
         end
      end
   end

   assign o_in_ready   = w_in_ready;
   assign o_out_valid  = r_out_valid;
   assign o_out_data   = r_out_data;
   assign o_blk_cnt    = r_blk_cnt;
   assign o_cnt_sat    = w_cnt_max;
   assign o_alarm      = r_alarm;
   assign o_alarm_code = r_alarm_code;

endmodule

// File: tb/tb_rc5_out_monitor.sv
// tb/tb_rc5_out_monitor.sv - scoreboard bench for rc5_out_monitor (main instance CNT_W=4 with
// saturation alarm, second instance CNT_W=4 without)
module tb_rc5_out_monitor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, clr, in_valid, out_ready;
   logic [63:0] in_data;
   logic        in_ready, out_valid, cnt_sat, alarm;
   logic [63:0] out_data;
   logic [3:0]  blk_cnt;
   logic [1:0]  alarm_code;

   logic        n_in_valid;
   logic [63:0] n_in_data;
   logic        n_in_ready, n_out_valid, n_cnt_sat, n_alarm;
   logic [63:0] n_out_data;
   logic [3:0]  n_blk_cnt;
   logic [1:0]  n_alarm_code;

   rc5_out_monitor #(.DATA_W(64), .CNT_W(4), .STUCK_LIMIT(4), .SAT_ALARM_EN(1'b1)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr),
      .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
      .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
      .o_blk_cnt(blk_cnt), .o_cnt_sat(cnt_sat), .o_alarm(alarm), .o_alarm_code(alarm_code)
   );

   rc5_out_monitor #(.DATA_W(64), .CNT_W(4), .STUCK_LIMIT(4), .SAT_ALARM_EN(1'b0)) u_nsat (
      .i_clk(clk), .i_rst_n(rst_n), .i_clr(1'b0),
      .i_in_valid(n_in_valid), .o_in_ready(n_in_ready), .i_in_data(n_in_data),
      .o_out_valid(n_out_valid), .i_out_ready(1'b1), .o_out_data(n_out_data),
      .o_blk_cnt(n_blk_cnt), .o_cnt_sat(n_cnt_sat), .o_alarm(n_alarm), .o_alarm_code(n_alarm_code)
   );

   int n_vec = 0;
   int n_err = 0;
   logic [63:0] exp_q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // monitor: a block presented with out_ready high at the negedge transfers on the next posedge
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_unexpected: got %h expected no block", out_data);
         end else begin
            chk("sb_data", out_data, exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [63:0] d, input bit fwd);
      int t = 0;
      in_valid = 1'b1;
      in_data  = d;
      #1;
      while (in_ready !== 1'b1 && t < 50) begin
         tick();
         t++;
      end
      if (in_ready !== 1'b1) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout: got in_ready %b expected 1", in_ready);
      end else if (fwd) begin
         exp_q.push_back(d);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
      n_in_valid = 1'b0; n_in_data = '0;
      tick();
      chk("rst_in_ready_low", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_blk_cnt", blk_cnt, 0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready_high", in_ready, 1);
      chk("rst_alarm", alarm, 0);

      // 1: three distinct blocks, latency 1, full throughput
      send(64'h0123_4567_89AB_CDEF, 1'b1);
      chk("t1_lat_valid", out_valid, 1);
      chk("t1_lat_data", out_data, 64'h0123_4567_89AB_CDEF);
      send(64'hFEDC_BA98_7654_3210, 1'b1);
      send(64'h0000_0000_0000_0000, 1'b1);
      tick();
      chk("t1_blk_cnt", blk_cnt, 3);
      chk("t1_alarm", alarm, 0);

      // 4b: saturation without alarm on the second instance
      for (int i = 0; i < 16; i++) begin
         n_in_valid = 1'b1;
         n_in_data  = 64'h3000 + 64'(i);
         tick();
         chk("t4b_fwd_valid", n_out_valid, 1);
         chk("t4b_fwd_data", n_out_data, 64'h3000 + 64'(i));
         chk("t4b_blk_cnt", n_blk_cnt, (i < 15) ? 64'(i + 1) : 64'd15);
         chk("t4b_cnt_sat", n_cnt_sat, (i >= 14) ? 64'd1 : 64'd0);
      end
      n_in_valid = 1'b0;
      chk("t4b_alarm", n_alarm, 0);

      // 2: back-pressure holds the first block, second waits
      pulse_clr();
      out_ready = 1'b0;
      send(64'hAAAA_0000_0000_0001, 1'b1);
      in_valid = 1'b1;
      in_data  = 64'hAAAA_0000_0000_0002;
      #1;
      chk("t2_in_ready_low", in_ready, 0);
      chk("t2_hold_data0", out_data, 64'hAAAA_0000_0000_0001);
      tick();
      chk("t2_hold_valid", out_valid, 1);
      chk("t2_hold_data1", out_data, 64'hAAAA_0000_0000_0001);
      out_ready = 1'b1;
      send(64'hAAAA_0000_0000_0002, 1'b1);
      tick();
      chk("t2_blk_cnt", blk_cnt, 2);

      // 3: four identical blocks trip the stuck alarm
      pulse_clr();
      for (int i = 0; i < 4; i++) send(64'hDEAD_BEEF_0000_0001, (i < 3));
      chk("t3_alarm", alarm, 1);
      chk("t3_alarm_code", alarm_code, 2'b01);
      chk("t3_in_ready", in_ready, 0);
      chk("t3_blk_cnt", blk_cnt, 4);
      chk("t3_out_valid", out_valid, 0);

      // 5: clr with in_valid in ALARM, clr wins
      in_valid = 1'b1;
      in_data  = 64'h5555_0000_0000_0005;
      clr      = 1'b1;
      #1;
      chk("t5_in_ready_clr", in_ready, 0);
      tick();
      clr      = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("t5_alarm", alarm, 0);
      chk("t5_alarm_code", alarm_code, 0);
      chk("t5_blk_cnt", blk_cnt, 0);
      chk("t5_in_ready", in_ready, 1);
      send(64'h5555_0000_0000_0005, 1'b1);
      chk("t5_blk_cnt_after", blk_cnt, 1);

      // 4a: saturation alarm on the 15th block
      pulse_clr();
      for (int i = 0; i < 14; i++) send(64'h1000 + 64'(i), 1'b1);
      chk("t4a_blk_cnt14", blk_cnt, 14);
      chk("t4a_cnt_sat14", cnt_sat, 0);
      send(64'h2000, 1'b0);
      chk("t4a_blk_cnt15", blk_cnt, 15);
      chk("t4a_cnt_sat15", cnt_sat, 1);
      chk("t4a_alarm", alarm, 1);
      chk("t4a_alarm_code", alarm_code, 2'b10);

      // 6: asynchronous reset while a block is held
      pulse_clr();
      out_ready = 1'b0;
      send(64'h6666_0000_0000_0006, 1'b1);
      chk("t6_held_valid", out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_out_valid", out_valid, 0);
      chk("t6_rst_blk_cnt", blk_cnt, 0);
      exp_q.delete();
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("t6_in_ready", in_ready, 1);
      send(64'h7777_0000_0000_0007, 1'b1);
      tick();
      tick();
      chk("sb_drained", 64'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
